// File: rtl/adc_sequencer_if.sv
// Bundle of the sequencer's control, strobe and result signals between the
// ADC digital block (slave side: the sequencer) and its controller/consumer.
interface adc_sequencer_if #(
    parameter int NCOMP_MAX = 16
);
    logic                 start;
    logic                 cont;
    logic [3:0]           cfg_samp_len;
    logic [4:0]           cfg_ncomp;
    logic                 comp_out;
    logic                 seq_init;
    logic                 seq_samp;
    logic                 seq_comp;
    logic                 seq_update;
    logic                 busy;
    // Result handshake: a word transfers on any rising edge where result_valid
    // and result_ready are both high; result_valid never drops without that
    // transfer (or reset), and a new load while still valid overwrites it.
    logic [NCOMP_MAX-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 overrun;
    logic                 clr_overrun;
    logic [5:0]           state_dbg;

    modport master (
        output start, cont, cfg_samp_len, cfg_ncomp, comp_out, result_ready, clr_overrun,
        input  seq_init, seq_samp, seq_comp, seq_update, busy,
               result, result_valid, overrun, state_dbg
    );

    modport slave (
        input  start, cont, cfg_samp_len, cfg_ncomp, comp_out, result_ready, clr_overrun,
        output seq_init, seq_samp, seq_comp, seq_update, busy,
               result, result_valid, overrun, state_dbg
    );
endinterface

// File: rtl/adc_sequencer.sv
// SAR ADC conversion sequencer: INIT, SAMP, then COMP/UPDATE pairs collecting
// comparator decisions MSB-first, DONE publishes the word with overrun tracking.
module adc_sequencer #(
    parameter int NCOMP_MAX = 16,
    parameter int SAMP_MAX  = 15
) (
    input logic             clk,
    input logic             rst,
    adc_sequencer_if.slave  bus
);
    localparam logic [3:0] SAMP_MAX_W  = 4'(SAMP_MAX);
    localparam logic [4:0] NCOMP_MAX_W = 5'(NCOMP_MAX);

    // One-hot so each phase strobe is a bare flip-flop output.
    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        INIT   = 6'b000010,
        SAMP   = 6'b000100,
        COMP   = 6'b001000,
        UPDATE = 6'b010000,
        DONE   = 6'b100000
    } state_t;

    state_t               state;
    logic [5:0]           state_bits;
    logic                 busy_q;
    logic [3:0]           samp_left;
    logic [4:0]           ncomp_lat;
    logic [4:0]           dec_cnt;
    logic [NCOMP_MAX-1:0] shreg;
    logic [NCOMP_MAX-1:0] bit_ptr;
    logic [NCOMP_MAX-1:0] result_q;
    logic                 result_valid_q;
    logic                 overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            samp_left      <= '0;
            ncomp_lat      <= '0;
            dec_cnt        <= '0;
            shreg          <= '0;
            bit_ptr        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= INIT;
                        busy_q <= 1'b1;
                    end
                end
                INIT: begin
                    if (bus.cfg_samp_len == 4'd0)
                        samp_left <= 4'd1;
                    else if (bus.cfg_samp_len > SAMP_MAX_W)
                        samp_left <= SAMP_MAX_W;
                    else
                        samp_left <= bus.cfg_samp_len;
                    if (bus.cfg_ncomp == 5'd0 || bus.cfg_ncomp > NCOMP_MAX_W)
                        ncomp_lat <= NCOMP_MAX_W;
                    else
                        ncomp_lat <= bus.cfg_ncomp;
                    dec_cnt <= '0;
                    shreg   <= '0;
                    bit_ptr <= {1'b1, {(NCOMP_MAX-1){1'b0}}};
                    state   <= SAMP;
                end
                SAMP: begin
                    if (samp_left <= 4'd1)
                        state <= COMP;
                    else
                        samp_left <= samp_left - 4'd1;
                end
                COMP: state <= UPDATE;
                UPDATE: begin
                    // bit_ptr walks from the MSB down, one position per decision.
                    if (bus.comp_out)
                        shreg <= shreg | bit_ptr;
                    bit_ptr <= bit_ptr >> 1;
                    dec_cnt <= dec_cnt + 5'd1;
                    if (dec_cnt + 5'd1 >= ncomp_lat)
                        state <= DONE;
                    else
                        state <= COMP;
                end
                DONE: begin
                    if (bus.cont) begin
                        state <= INIT;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // A load at the same edge as a transfer keeps valid high, no overrun.
            if (state == DONE) begin
                result_q       <= shreg;
                result_valid_q <= 1'b1;
                if (result_valid_q && !bus.result_ready)
                    overrun_q <= 1'b1;
                else if (bus.clr_overrun)
                    overrun_q <= 1'b0;
            end else begin
                if (result_valid_q && bus.result_ready)
                    result_valid_q <= 1'b0;
                if (bus.clr_overrun)
                    overrun_q <= 1'b0;
            end
        end
    end

    assign state_bits       = state;
    assign bus.seq_init     = state_bits[1];
    assign bus.seq_samp     = state_bits[2];
    assign bus.seq_comp     = state_bits[3];
    assign bus.seq_update   = state_bits[4];
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.state_dbg    = state_bits;
endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: a phase-schedule reference model predicts every
// cycle; directed scenarios plus a randomized soak drive the sequencer.
module tb_adc_sequencer;
    localparam int N      = 16;
    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_SAMP = 2;
    localparam int P_COMP = 3;
    localparam int P_UPD  = 4;
    localparam int P_DONE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_sequencer_if #(.NCOMP_MAX(N)) bus ();
    adc_sequencer #(.NCOMP_MAX(N), .SAMP_MAX(15)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each conversion is a list of phases built when INIT ends.
    int           m_ph = P_IDLE;
    int           ph_q[$];
    logic         dec_q[$];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] m_result = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_load = 1'b0;
    int           m_done_cnt = 0;
    logic         mon_en = 1'b0;
    int           comp_mode = 0;

    always @(posedge clk) begin : model
        int s;
        int n;
        logic [N-1:0] word;
        logic ovr_set;
        m_load = 1'b0;
        ovr_set = 1'b0;
        if (rst) begin
            m_ph = P_IDLE;
            ph_q.delete();
            dec_q.delete();
            exp_q.delete();
            m_result = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.start) ph_q.push_back(P_INIT);
                P_INIT: begin
                    s = (bus.cfg_samp_len == 0) ? 1 : int'(bus.cfg_samp_len);
                    n = (bus.cfg_ncomp == 0 || int'(bus.cfg_ncomp) > N) ? N : int'(bus.cfg_ncomp);
                    repeat (s) ph_q.push_back(P_SAMP);
                    repeat (n) begin
                        ph_q.push_back(P_COMP);
                        ph_q.push_back(P_UPD);
                    end
                    ph_q.push_back(P_DONE);
                    dec_q.delete();
                end
                P_UPD: dec_q.push_back(bus.comp_out);
                P_DONE: begin
                    word = '0;
                    foreach (dec_q[k]) word[N-1-k] = dec_q[k];
                    ovr_set = m_valid && !bus.result_ready;
                    m_result = word;
                    m_valid = 1'b1;
                    m_load = 1'b1;
                    exp_q.push_back(word);
                    m_done_cnt++;
                    if (bus.cont) ph_q.push_back(P_INIT);
                end
                default: ;
            endcase
            if (!m_load && m_valid && bus.result_ready) m_valid = 1'b0;
            if (ovr_set) m_ovr = 1'b1;
            else if (bus.clr_overrun) m_ovr = 1'b0;
            m_ph = (ph_q.size() > 0) ? ph_q.pop_front() : P_IDLE;
        end
    end

    // Per-cycle scoreboard against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("seq", {bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update},
                  {m_ph == P_INIT, m_ph == P_SAMP, m_ph == P_COMP, m_ph == P_UPD});
            check("state", bus.state_dbg, 64'(1) << m_ph);
            check("busy", bus.busy, m_ph != P_IDLE);
            check("result_valid", bus.result_valid, m_valid);
            check("overrun", bus.overrun, m_ovr);
            check("result", bus.result, m_result);
            if (m_load) begin
                if (exp_q.size() == 0) check("load_queue", 0, 1);
                else check("load_word", bus.result, exp_q.pop_front());
            end
        end
    end

    // Comparator stimulus: random, alternating by decision index, or all ones.
    always @(negedge clk) begin
        case (comp_mode)
            1:       bus.comp_out = (dec_q.size() % 2 == 0);
            2:       bus.comp_out = 1'b1;
            default: bus.comp_out = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic measure(input logic iso, output int nb, output int ns, output int nc);
        int guard;
        nb = 0; ns = 0; nc = 0; guard = 0;
        while (bus.busy !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("busy_rise", bus.busy, 1);
        guard = 0;
        while (bus.busy === 1'b1 && guard < 500) begin
            nb++;
            ns += int'(bus.seq_samp);
            nc += int'(bus.seq_comp);
            if (iso && bus.seq_samp) bus.cfg_ncomp = 5'd2;
            @(negedge clk);
            guard++;
        end
        check("busy_fall_timeout", guard < 500, 1);
    endtask

    task automatic wait_ph(input int ph, input int nd);
        int guard;
        guard = 0;
        while (!(m_ph == ph && (nd < 0 || dec_q.size() == nd)) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("wait_phase_timeout", guard < 500, 1);
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (m_done_cnt < target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("wait_done_timeout", guard < 500, 1);
    endtask

    initial begin
        int nb, ns, nc, base, guard;
        bus.start = 0; bus.cont = 0; bus.cfg_samp_len = 0; bus.cfg_ncomp = 0;
        bus.result_ready = 0; bus.clr_overrun = 0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_valid", bus.result_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single shot, alternating decisions.
        comp_mode = 1; bus.cfg_samp_len = 4'd2; bus.cfg_ncomp = 5'd16;
        pulse_start();
        measure(1'b0, nb, ns, nc);
        check("single_busy_len", nb, 36);
        check("single_samp", ns, 2);
        check("single_comp", nc, 16);
        check("single_result", bus.result, 16'hAAAA);
        check("single_valid", bus.result_valid, 1);

        // Clamping of zero configuration, then a short all-ones conversion.
        comp_mode = 0; bus.result_ready = 1; bus.cfg_samp_len = 4'd0; bus.cfg_ncomp = 5'd0;
        pulse_start();
        measure(1'b0, nb, ns, nc);
        check("clamp_busy_len", nb, 35);
        check("clamp_samp", ns, 1);
        check("clamp_comp", nc, 16);
        comp_mode = 2; bus.cfg_ncomp = 5'd4;
        pulse_start();
        measure(1'b0, nb, ns, nc);
        check("short_busy_len", nb, 11);
        check("short_result", bus.result, 16'hF000);
        repeat (2) @(negedge clk);

        // Continuous mode with an unread result.
        comp_mode = 0; bus.result_ready = 0; bus.cfg_samp_len = 4'd1; bus.cfg_ncomp = 5'd3;
        bus.cont = 1; base = m_done_cnt;
        pulse_start();
        wait_done(base + 1);
        check("cont_ovr_first", bus.overrun, 0);
        wait_done(base + 2);
        check("cont_ovr_second", bus.overrun, 1);
        bus.clr_overrun = 1; @(negedge clk); bus.clr_overrun = 0;
        check("cont_ovr_cleared", bus.overrun, 0);
        wait_ph(P_COMP, -1);
        bus.cont = 0;
        wait_done(base + 3);
        check("cont_stop_idle", bus.busy, 0);
        @(negedge clk);
        check("cont_still_idle", bus.busy, 0);

        // Back-to-back: consumer ready only during DONE cycles.
        bus.result_ready = 1; bus.clr_overrun = 1; @(negedge clk);
        bus.clr_overrun = 0; bus.result_ready = 0; @(negedge clk);
        check("b2b_pre_ovr", bus.overrun, 0);
        bus.cfg_samp_len = 4'd0; bus.cfg_ncomp = 5'd2; bus.cont = 1; base = m_done_cnt;
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            guard = 0;
            while (m_done_cnt < base + i && guard < 200) begin
                bus.result_ready = (m_ph == P_DONE);
                @(negedge clk);
                guard++;
            end
            bus.result_ready = (m_ph == P_DONE);
            check("b2b_timeout", guard < 200, 1);
            check("b2b_valid", bus.result_valid, 1);
            check("b2b_ovr", bus.overrun, 0);
            if (i == 2) bus.cont = 0;
        end
        bus.result_ready = 1;
        repeat (3) @(negedge clk);
        check("b2b_idle", bus.busy, 0);

        // Reset during the 5th UPDATE, start held alongside reset.
        bus.result_ready = 0; bus.cfg_samp_len = 4'd2; bus.cfg_ncomp = 5'd8; base = m_done_cnt;
        pulse_start();
        wait_ph(P_UPD, 4);
        rst = 1; bus.start = 1;
        @(negedge clk);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_seq", {bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update}, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_valid", bus.result_valid, 0);
        check("rst_mid_ovr", bus.overrun, 0);
        @(negedge clk);
        check("rst_start_ignored", bus.busy, 0);
        check("rst_no_result", m_done_cnt - base, 0);
        rst = 0; bus.start = 0;
        @(negedge clk);
        pulse_start();
        measure(1'b0, nb, ns, nc);
        check("post_rst_len", nb, 20);
        check("post_rst_valid", bus.result_valid, 1);

        // Config change during SAMP must not affect the running conversion.
        bus.result_ready = 1; bus.cfg_samp_len = 4'd3; bus.cfg_ncomp = 5'd8;
        pulse_start();
        measure(1'b1, nb, ns, nc);
        check("iso_comp", nc, 8);
        check("iso_len", nb, 21);

        // Randomized soak against the model.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.cont = 1'($urandom_range(0, 1));
            bus.cfg_samp_len = 4'($urandom_range(0, 15));
            bus.cfg_ncomp = 5'($urandom_range(0, 31));
            bus.result_ready = 1'($urandom_range(0, 1));
            bus.clr_overrun = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        rst = 0; bus.start = 0; bus.cont = 0; bus.clr_overrun = 0;
        guard = 0;
        while (m_ph != P_IDLE && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("final_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
